decode_stage_pipe: RTL and testbench
====================================

# decode_stage_pipe

Parametrised MIPS instruction-decode pipeline stage. It sits between the fetch and execute stages. It contains the architectural register file and splits each accepted instruction into its fields. It extends the immediate, reads both source operands and registers the result behind a valid/ready handshake. Beyond plain decoding it adds back-pressure, a one-bubble load-use hazard interlock, a pipeline flush, a stall counter and optional writeback-to-decode bypass.

## Interface
Parameters:
- DATA_W, 32, register and immediate data width; must be ≥ 16.
- REG_CNT, 32, number of registers; power of two, 2..32.
- AW, $clog2(REG_CNT), register address width (derived; not overridden).

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of the output register.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts in_instr this cycle.
- in_instr  in  32  MIPS instruction word.
- wb_en  in  1  writeback write enable.
- wb_addr  in  AW  writeback destination register.
- wb_data  in  DATA_W  writeback data.
- out_valid  out  1  decoded instruction available to execute.
- out_ready  in  1  execute accepts the decoded instruction.
- out_opcode  out  6  instr[31:26].
- out_funct  out  6  instr[5:0].
- out_rs, out_rt, out_rd  out  AW each  instr[25:21], [20:16], [15:11], low AW bits.
- out_shamt  out  5  instr[10:6].
- out_imm  out  DATA_W  extended instr[15:0].
- out_rs_data, out_rt_data  out  DATA_W  register operands.
- out_is_load  out  1  opcode is 6'h23 (LW).
- stall_cnt  out  16  saturating count of load-use bubbles.

## Operation
- Register file: REG_CNT × DATA_W flops.
  - Written at the Clk edge when wb_en=1 and wb_addr≠0.
  - Register 0 always reads 0; writes to it are ignored.
- Immediate extension:
  - Opcodes 6'h0C (ANDI), 6'h0D (ORI) and 6'h0E (XORI) zero-extend.
  - All other opcodes sign-extend from bit 15.
- Operand read is combinational from in_instr.
  - Fields and operands are captured into the output register on accept.
- Load-use hazard: hazard = out_valid & out_is_load & out_rt≠0 & in_valid & (in rs==out_rt | in rt==out_rt).
  - Compare only the low AW bits of the instruction fields.
- in_ready = (~out_valid | out_ready) & ~hazard & ~flush.
- Output register update on each Clk edge, in priority order:
  1. flush=1: out_valid←0.
  2. in_valid & in_ready: load all fields and operands; out_valid←1.
  3. out_ready & hazard: out_valid←0 (bubble); stall_cnt increments, saturating at 16'hFFFF.
  4. out_ready: out_valid←0.
  5. Otherwise: hold all outputs unchanged.
- Output fields are don't-care while out_valid=0, but hold their last value.

## Timing
- Reset (Rst_n=0, asynchronous):
  - out_valid=0 and stall_cnt=0.
  - All out_* data fields = 0.
  - Every register = 0.
  - An in-flight instruction is dropped.
- in_ready is 0 while Rst_n=0.
- Latency: an instruction accepted at edge N is presented with out_valid=1 from edge N until its out_ready handshake.
- Full throughput of 1 instruction/cycle when out_ready=1 and no hazard.
- A load-use hazard costs exactly one bubble cycle.
  - On the following cycle out_valid=0, so the hazard term is 0 and the dependent instruction is accepted.
- Back-pressure: with out_valid=1 and out_ready=0, the outputs are stable and in_ready=0.
- Simultaneous writeback and read of the same register: see Configuration.
- Flush coincident with in_valid: the instruction is not accepted (in_ready=0), and fetch must re-present it.

## Configuration
- DECODE_BYPASS_EN defined:
  - When wb_en=1 and wb_addr≠0 matches the register being read, the captured operand is wb_data in the same cycle (write-through).
- DECODE_BYPASS_EN undefined:
  - The captured operand is the pre-write file value.
  - The writeback stage must schedule around it.

## Test plan
- Reset then write: assert Rst_n=0 mid-stream, then read r1..r31 → all operands 0 and out_valid=0. Then wb r5←32'hDEADBEEF; next ADD rs=5 → out_rs_data=32'hDEADBEEF.
- Immediates:
  - ADDI imm 16'h8000 → out_imm=32'hFFFF8000.
  - ORI imm 16'h8000 → out_imm=32'h00008000.
  - Write to r0 → reading r0 returns 0.
- Load-use: LW rt=8, then ADD rs=8, with out_ready held 1 → exactly one out_valid=0 cycle between them and stall_cnt=1. The same sequence with an ADD that does not use r8 → no bubble.
- Back-pressure: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and the outputs are unchanged. Release → one instruction per cycle resumes with no loss or duplication.
- Bypass: wb r9←32'h12345678 in the same cycle the ADD rs=9 is accepted.
  - With DECODE_BYPASS_EN → out_rs_data=32'h12345678.
  - Without it → the old r9 value.
- Flush: assert flush while out_valid=1 and in_valid=1 → next edge out_valid=0, the instruction is not accepted and stall_cnt is unchanged.

Source files
------------

// File: rtl/decode_stage_pipe.sv
// ---------------------------------------------------------------------------
// decode_stage_pipe
//
// MIPS instruction-decode pipeline stage. It holds the architectural register
// file and splits each accepted instruction into its fields. It extends the
// immediate and reads both source operands. The decoded result is registered
// behind a valid/ready handshake. The stage also provides:
//   - a one-bubble load-use interlock
//   - a synchronous flush of the output register
//   - a saturating stall counter
//
// Build option:
//   DECODE_BYPASS_EN - when defined, a same-cycle writeback to a register being
//                      read is forwarded into the captured operand. When it is
//                      undefined, the pre-write register file value is captured.
//
// Ports:
//   Clk, Rst_n           clock, asynchronous active-low reset
//   flush                squash the output register at the next edge
//   in_valid/in_ready    fetch-side handshake, in_instr = instruction word
//   wb_en/wb_addr/wb_data  writeback port into the register file
//   out_valid/out_ready  execute-side handshake
//   out_opcode/funct/rs/rt/rd/shamt/imm  decoded fields
//   out_rs_data/out_rt_data              register operands
//   out_is_load          opcode is LW
//   stall_cnt            saturating count of load-use bubbles
// ---------------------------------------------------------------------------
module decode_stage_pipe #(
    parameter int  DATA_W  = 32,
    parameter int  REG_CNT = 32,
    localparam int AW      = $clog2(REG_CNT)
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        out_opcode,
    output logic [5:0]        out_funct,
    output logic [AW-1:0]     out_rs,
    output logic [AW-1:0]     out_rt,
    output logic [AW-1:0]     out_rd,
    output logic [4:0]        out_shamt,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_rs_data,
    output logic [DATA_W-1:0] out_rt_data,
    output logic              out_is_load,
    output logic [15:0]       stall_cnt
);

    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;

    logic [DATA_W-1:0] regs [REG_CNT];

    logic [5:0]        in_opcode;
    logic [AW-1:0]     in_rs;
    logic [AW-1:0]     in_rt;
    logic [AW-1:0]     in_rd;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              hazard;
    logic              accept;

    assign in_opcode = in_instr[31:26];
    assign in_rs     = in_instr[21 +: AW];
    assign in_rt     = in_instr[16 +: AW];
    assign in_rd     = in_instr[11 +: AW];

    // Logical immediates zero-extend; everything else sign-extends.
    always_comb begin
        imm_ext = DATA_W'($signed(in_instr[15:0]));
        if (in_opcode == OP_ANDI || in_opcode == OP_ORI || in_opcode == OP_XORI)
            imm_ext = DATA_W'(in_instr[15:0]);
    end

    always_comb begin
        rs_data = (in_rs == '0) ? '0 : regs[in_rs];
        rt_data = (in_rt == '0) ? '0 : regs[in_rt];
`ifdef DECODE_BYPASS_EN
        if (wb_en && wb_addr != '0 && wb_addr == in_rs) rs_data = wb_data;
        if (wb_en && wb_addr != '0 && wb_addr == in_rt) rt_data = wb_data;
`endif
    end

    // A load in the output register whose destination feeds the incoming
    // instruction holds it off for one cycle.
    assign hazard = out_valid && out_is_load && (out_rt != '0) && in_valid &&
                    ((in_rs == out_rt) || (in_rt == out_rt));

    assign in_ready = Rst_n && (!out_valid || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int unsigned i = 0; i < REG_CNT; i++) regs[i] <= '0;
        end else if (wb_en && wb_addr != '0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_valid   <= 1'b0;
            out_opcode  <= '0;
            out_funct   <= '0;
            out_rs      <= '0;
            out_rt      <= '0;
            out_rd      <= '0;
            out_shamt   <= '0;
            out_imm     <= '0;
            out_rs_data <= '0;
            out_rt_data <= '0;
            out_is_load <= 1'b0;
            stall_cnt   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_opcode  <= in_opcode;
            out_funct   <= in_instr[5:0];
            out_rs      <= in_rs;
            out_rt      <= in_rt;
            out_rd      <= in_rd;
            out_shamt   <= in_instr[10:6];
            out_imm     <= imm_ext;
            out_rs_data <= rs_data;
            out_rt_data <= rt_data;
            out_is_load <= (in_opcode == OP_LW);
        end else if (out_ready && hazard) begin
            out_valid <= 1'b0;
            if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// ---------------------------------------------------------------------------
// tb_decode_stage_pipe
//
// Directed self-checking bench for decode_stage_pipe (default parameters).
// Inputs change 1 time unit after a rising edge. Outputs are sampled at the
// same point, so they are checked away from the active edge.
// The expected bypass value follows DECODE_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_decode_stage_pipe;

    localparam int DATA_W  = 32;
    localparam int REG_CNT = 32;
    localparam int AW      = 5;

    logic              Clk = 1'b0;
    logic              Rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic              wb_en;
    logic [AW-1:0]     wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [5:0]        out_opcode;
    logic [5:0]        out_funct;
    logic [AW-1:0]     out_rs;
    logic [AW-1:0]     out_rt;
    logic [AW-1:0]     out_rd;
    logic [4:0]        out_shamt;
    logic [DATA_W-1:0] out_imm;
    logic [DATA_W-1:0] out_rs_data;
    logic [DATA_W-1:0] out_rt_data;
    logic              out_is_load;
    logic [15:0]       stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    decode_stage_pipe #(.DATA_W(DATA_W), .REG_CNT(REG_CNT)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_funct(out_funct),
        .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_shamt(out_shamt), .out_imm(out_imm),
        .out_rs_data(out_rs_data), .out_rt_data(out_rt_data),
        .out_is_load(out_is_load), .stall_cnt(stall_cnt)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    logic [31:0] bypass_exp;

    initial begin
`ifdef DECODE_BYPASS_EN
        bypass_exp = 32'h12345678;
`else
        bypass_exp = 32'h11111111;
`endif
        Rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_instr = rtype(5'd1, 5'd2, 5'd3);
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;

        // Reset state
        #2;
        chk("reset_in_ready", 96'(in_ready), 96'(0));
        chk("reset_valid_stall", {out_valid, stall_cnt}, 96'(0));
        chk("reset_fields", {out_imm, out_rs_data, out_rt_data}, 96'(0));
        tick(); tick();
        Rst_n = 1'b1; in_valid = 1'b0;

        // Preload r3, r8
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hA5A5A5A5; tick();
        wb_addr = 5'd8; wb_data = 32'h00000088; tick();
        wb_en = 1'b0;

        // Immediates
        in_valid = 1'b1; in_instr = itype(6'h08, 5'd0, 5'd1, 16'h8000); tick();
        chk("addi_sext", {out_valid, out_imm}, {1'b1, 32'hFFFF8000});
        in_instr = itype(6'h0D, 5'd0, 5'd1, 16'h8000); tick();
        chk("ori_zext", 96'(out_imm), 96'(32'h00008000));
        in_instr = itype(6'h0E, 5'd0, 5'd1, 16'hFFFF); tick();
        chk("xori_zext", 96'(out_imm), 96'(32'h0000FFFF));
        in_instr = itype(6'h0C, 5'd3, 5'd8, 16'h7FFF); tick();
        chk("andi_ops", {out_imm, out_rs_data, out_rt_data},
            {32'h00007FFF, 32'hA5A5A5A5, 32'h00000088});

        // Write to r0 is ignored
        in_valid = 1'b0; wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h55555555; tick();
        wb_en = 1'b0; in_valid = 1'b1; in_instr = rtype(5'd0, 5'd0, 5'd4); tick();
        chk("r0_read", {out_valid, out_rs_data, out_rt_data}, {1'b1, 64'd0});

        // Load-use on rs: exactly one bubble
        in_instr = itype(6'h23, 5'd0, 5'd8, 16'h0004); tick();
        chk("lw_out", {out_is_load, out_rt}, {1'b1, 5'd8});
        in_instr = rtype(5'd8, 5'd0, 5'd10);
        #1 chk("hazard_in_ready", 96'(in_ready), 96'(0));
        tick();
        chk("bubble_rs", {out_valid, stall_cnt}, {1'b0, 16'd1});
        tick();
        chk("after_bubble", {out_valid, out_rd, out_rs_data}, {1'b1, 5'd10, 32'h00000088});
        // Independent instruction after load: no bubble
        in_instr = itype(6'h23, 5'd0, 5'd8, 16'h0004); tick();
        in_instr = rtype(5'd9, 5'd10, 5'd12);
        #1 chk("nohaz_in_ready", 96'(in_ready), 96'(1));
        tick();
        chk("no_bubble", {out_valid, out_rd, stall_cnt}, {1'b1, 5'd12, 16'd1});
        // Load-use on rt
        in_instr = itype(6'h23, 5'd0, 5'd8, 16'h0004); tick();
        in_instr = rtype(5'd0, 5'd8, 5'd13); tick();
        chk("bubble_rt", {out_valid, stall_cnt}, {1'b0, 16'd2});
        tick();
        chk("after_bubble_rt", {out_valid, out_rd}, {1'b1, 5'd13});
        // Load to r0 never interlocks
        in_instr = itype(6'h23, 5'd0, 5'd0, 16'h0004); tick();
        in_instr = rtype(5'd0, 5'd0, 5'd14); tick();
        chk("lw_r0_nohaz", {out_valid, out_rd, stall_cnt}, {1'b1, 5'd14, 16'd2});

        // Back-pressure
        in_instr = rtype(5'd1, 5'd2, 5'd13); tick();
        out_ready = 1'b0; in_instr = itype(6'h0D, 5'd0, 5'd12, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_in_ready", 96'(in_ready), 96'(0));
            tick();
            chk("bp_hold", {out_valid, out_rd, out_opcode}, {1'b1, 5'd13, 6'h00});
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", 96'(in_ready), 96'(1));
        tick();
        chk("bp_x", {out_valid, out_rt, out_imm}, {1'b1, 5'd12, 32'h00001234});
        in_instr = itype(6'h08, 5'd0, 5'd14, 16'h0007); tick();
        chk("bp_y", {out_valid, out_rt, out_imm}, {1'b1, 5'd14, 32'h00000007});
        in_valid = 1'b0; tick();
        chk("bp_drain", 96'(out_valid), 96'(0));

        // Mid-stream asynchronous reset
        in_valid = 1'b1; in_instr = rtype(5'd3, 5'd8, 5'd1); tick();
        chk("pre_reset", {out_valid, out_rs_data, out_rt_data}, {1'b1, 32'hA5A5A5A5, 32'h88});
        #3 Rst_n = 1'b0;
        #1;
        chk("async_reset", {out_valid, stall_cnt, out_imm}, 96'(0));
        chk("async_in_ready", 96'(in_ready), 96'(0));
        tick();
        Rst_n = 1'b1;
        for (int i = 1; i < 32; i++) begin
            in_instr = rtype(5'(i), 5'(i), 5'd1);
            tick();
            chk("reg_cleared", {out_valid, out_rs_data, out_rt_data}, {1'b1, 64'd0});
        end

        // Write then read
        in_valid = 1'b0; wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF; tick();
        wb_en = 1'b0; in_valid = 1'b1; in_instr = rtype(5'd5, 5'd0, 5'd2); tick();
        chk("wr_rd_r5", {out_valid, out_rs_data}, {1'b1, 32'hDEADBEEF});

        // Same-cycle writeback and read
        in_valid = 1'b0; wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h11111111; tick();
        wb_data = 32'h12345678; in_valid = 1'b1; in_instr = rtype(5'd9, 5'd0, 5'd11); tick();
        wb_en = 1'b0;
        chk("bypass", {out_valid, out_rs_data}, {1'b1, bypass_exp});
        tick();
        chk("after_wb", {out_rs_data, out_imm}, {32'h12345678, 32'h00005820});

        // Flush with in_valid
        flush = 1'b1; in_instr = itype(6'h08, 5'd0, 5'd1, 16'h0055);
        #1 chk("flush_in_ready", 96'(in_ready), 96'(0));
        tick();
        chk("flush_out", {out_valid, out_imm, stall_cnt}, {1'b0, 32'h00005820, 16'd0});
        flush = 1'b0; tick();
        chk("after_flush", {out_valid, out_imm}, {1'b1, 32'h00000055});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
